// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: resolves taken branches, JAL and JALR from EX into a fetch redirect,
// flushes IF/ID for FLUSH_CYCLES cycles and traps misaligned targets to TRAP_VEC.
module branch_redirect_unit #(
  parameter int                   VAR_WIDTH    = 32,
  parameter logic [VAR_WIDTH-1:0] RESET_PC     = '0,
  parameter logic [VAR_WIDTH-1:0] TRAP_VEC     = VAR_WIDTH'(32'h0000_0100),
  parameter int                   FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jal,
  input  logic                 ex_is_jalr,
  input  logic                 cmp_out,
  input  logic [VAR_WIDTH-1:0] ex_pc,
  input  logic [VAR_WIDTH-1:0] ex_imm,
  input  logic [VAR_WIDTH-1:0] ex_rs1,
  input  logic                 stall_i,
  input  logic                 fetch_ready,
  output logic [VAR_WIDTH-1:0] fetch_pc,
  output logic                 fetch_valid,
  output logic                 flush_o,
  output logic [VAR_WIDTH-1:0] link_addr,
  output logic                 trap_o
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t               state;
  logic [2:0]           cnt;
  logic                 redirect;
  logic [VAR_WIDTH-1:0] target;
  logic                 misaligned;

  // JALR takes its base from rs1 and clears bit 0; branch/JAL are PC-relative.
  function automatic logic [VAR_WIDTH-1:0] calc_target(
    input logic                 is_jalr,
    input logic [VAR_WIDTH-1:0] pc,
    input logic [VAR_WIDTH-1:0] imm,
    input logic [VAR_WIDTH-1:0] rs1
  );
    logic [VAR_WIDTH-1:0] sum;
    sum = is_jalr ? (rs1 + imm) : (pc + imm);
    if (is_jalr) sum[0] = 1'b0;
    return sum;
  endfunction

  assign redirect   = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & cmp_out));
  assign target     = calc_target(ex_is_jalr, ex_pc, ex_imm, ex_rs1);
  assign misaligned = (target[1:0] != 2'b00);
  assign link_addr  = ex_pc + VAR_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b0;
      flush_o     <= 1'b0;
      trap_o      <= 1'b0;
      cnt         <= 3'd0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
          trap_o      <= 1'b0;
        end
        RUN: begin
          if (redirect) begin
            // Redirect wins over stall and fetch_ready.
            fetch_pc    <= misaligned ? TRAP_VEC : target;
            trap_o      <= misaligned;
            flush_o     <= 1'b1;
            fetch_valid <= 1'b0;
            cnt         <= CNT_INIT;
            state       <= (FLUSH_CYCLES == 1) ? RUN : FLUSH;
          end else begin
            trap_o      <= 1'b0;
            flush_o     <= 1'b0;
            fetch_valid <= 1'b1;
            if (fetch_valid && fetch_ready && !stall_i)
              fetch_pc <= fetch_pc + VAR_WIDTH'(4);
          end
        end
        FLUSH: begin
          trap_o <= 1'b0;
          if (cnt == 3'd0) begin
            state       <= RUN;
            flush_o     <= 1'b0;
            fetch_valid <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
